calc1_req_driver: RTL and testbench
===================================

CALC1_REQ_DRIVER -- requirements
Module: calc1_req_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum WAIT_RSP cycles before a timeout completion.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 c_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  user request present.
REQ-006 req_ready  out  1  driver can accept a request.
REQ-007 req_cmd  in  4  CALC1 command code.
REQ-008 req_op1  in  32  operand 1.
REQ-009 req_op2  in  32  operand 2.
REQ-010 reqcmd_out  out  4  command to the CALC1 port.
REQ-011 req_data_out  out  32  operand data to the CALC1 port.
REQ-012 out_resp  in  2  CALC1 response code; 0 means none.
REQ-013 out_data  in  32  CALC1 result data.
REQ-014 rsp_valid  out  1  one-cycle completion pulse.
REQ-015 rsp_code  out  2  captured response code.
REQ-016 rsp_data  out  32  captured result.
REQ-017 rsp_timeout  out  1  completion was a timeout.
REQ-018 unexp_rsp  out  1  sticky flag: response seen outside WAIT_RSP.

Function
REQ-019 SHALL implement states IDLE, SEND_OP1, SEND_OP2, WAIT_RSP.
REQ-020 IDLE: req_ready=1, reqcmd_out=0, req_data_out=0.
REQ-021 In IDLE, req_valid=1 SHALL latch cmd/op1/op2 and move to SEND_OP1.
REQ-022 In all other states req_ready SHALL be 0; at most one request is outstanding.
REQ-023 SEND_OP1 (exactly 1 cycle): reqcmd_out=latched cmd, req_data_out=op1; then SEND_OP2.
REQ-024 SEND_OP2 (exactly 1 cycle): reqcmd_out=0, req_data_out=op2; then WAIT_RSP with wait counter cleared.
REQ-025 WAIT_RSP: outputs 0; the counter increments each cycle with out_resp==0.
REQ-026 In WAIT_RSP, out_resp!=0 SHALL capture out_resp/out_data, pulse rsp_valid for one cycle with rsp_timeout=0, and return to IDLE.
REQ-027 If the counter reaches TIMEOUT_CYCLES-1 with out_resp==0, the driver SHALL pulse rsp_valid with rsp_timeout=1, rsp_code=0, rsp_data=0, and return to IDLE.
REQ-028 A response and timeout in the same cycle SHALL be reported as the response (response wins).
REQ-029 Command codes SHALL be forwarded unchanged; invalid-command detection belongs to CALC1 (rsp_code=2).
REQ-030 out_resp!=0 in IDLE, SEND_OP1 or SEND_OP2 SHALL be ignored for data purposes and SHALL set unexp_rsp until reset.
REQ-031 rsp_code, rsp_data and rsp_timeout SHALL hold their values until the next completion.
REQ-032 Minimum issue-to-issue spacing SHALL be 4 cycles: request accept, op1, op2, then at least one WAIT cycle.

Reset
REQ-033 Reset SHALL force IDLE, clear the counter, and drive all outputs to 0 except req_ready=1 once reset is deasserted.
REQ-034 Reset mid-transaction SHALL abort the transaction without issuing a completion pulse; the in-flight response is discarded.

Structure
REQ-035 The shared package (calc1_pkg) SHALL hold: command codes (ADD=1, SUB=2, SHL=5, SHR=6), response codes (NONE=0, OK=1, ERR=2), the state enum, and the data width (32).
REQ-036 The design SHALL be a single module, with an optional sub-module calc1_wait_timer for the timeout counter.

Verification
REQ-037 ADD 5+7: req accepted -> cmd=1/data=5, then cmd=0/data=7 -> out_resp=1 with data 12 after 3 cycles -> rsp_valid, code 1, data 12.
REQ-038 Invalid cmd 3 -> forwarded as cmd 3; out_resp=2 -> rsp_code=2, rsp_timeout=0.
REQ-039 No response, TIMEOUT_CYCLES=8 -> rsp_valid exactly 8 WAIT cycles after SEND_OP2, with rsp_timeout=1, code 0.
REQ-040 Response arriving in the final timeout cycle -> reported as response, rsp_timeout=0.
REQ-041 Reset asserted during WAIT_RSP -> no rsp_valid; IDLE; req_ready=1 after reset release; a later out_resp sets unexp_rsp.
REQ-042 Back-to-back requests with req_valid held high -> second request accepted only in IDLE; req_ready low for the full first transaction.

Source files
------------

// File: rtl/calc1_pkg.sv
// ============================================================================
// Module  : calc1_pkg
// Brief   : Shared command/response codes, driver state encoding and data
//           width for the CALC1 request driver.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package calc1_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  // CALC1 command codes
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  // CALC1 response codes
  localparam logic [RESP_W-1:0] RSP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RSP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RSP_ERR  = 2'd2;

  // Driver states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_OP1 = 2'd1,
    ST_SEND_OP2 = 2'd2,
    ST_WAIT_RSP = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/calc1_wait_timer.sv
// ============================================================================
// Module  : calc1_wait_timer
// Brief   : Counts response-wait cycles and flags the last permitted cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module calc1_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic c_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A one-cycle timeout still needs a 1-bit counter
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear outside the wait state, advance on each wait cycle without a response
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/calc1_req_driver.sv
// ============================================================================
// Module  : calc1_req_driver
// Brief   : Accepts one user request, serialises cmd/op1/op2 onto the CALC1
//           port, then waits for a response or a timeout and reports it.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module calc1_req_driver
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic [CMD_W-1:0]  reqcmd_out,
  output logic [DATA_W-1:0] req_data_out,
  input  logic [RESP_W-1:0] out_resp,
  input  logic [DATA_W-1:0] out_data,
  output logic              rsp_valid,
  output logic [RESP_W-1:0] rsp_code,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              unexp_rsp
);

  state_e state_q, state_d;

  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RESP_W-1:0] rsp_code_q, rsp_code_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              unexp_q, unexp_d;

  logic in_wait;
  logic got_resp;
  logic expired;

  assign in_wait  = (state_q == ST_WAIT_RSP);
  assign got_resp = (out_resp != RSP_NONE);

  calc1_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .c_clk  (c_clk),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait && !got_resp),
    .expired(expired)
  );

  // State register
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed op1/op2 beats, then leave WAIT on response or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (req_valid) state_d = ST_SEND_OP1;
      ST_SEND_OP1: state_d = ST_SEND_OP2;
      ST_SEND_OP2: state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: if (got_resp || expired) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Port outputs decoded from state; ready stays low while reset is held
  always_comb begin
    req_ready    = 1'b0;
    reqcmd_out   = '0;
    req_data_out = '0;
    case (state_q)
      ST_IDLE:     req_ready = !reset;
      ST_SEND_OP1: begin
        reqcmd_out   = cmd_q;
        req_data_out = op1_q;
      end
      ST_SEND_OP2: req_data_out = op2_q;
      default:     ;
    endcase
  end

  // Request latch, completion capture (response beats timeout) and sticky flag
  always_comb begin
    cmd_d         = cmd_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    rsp_valid_d   = 1'b0;
    rsp_code_d    = rsp_code_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    unexp_d       = unexp_q | (!in_wait && got_resp);
    if (state_q == ST_IDLE && req_valid) begin
      cmd_d = req_cmd;
      op1_d = req_op1;
      op2_d = req_op2;
    end
    if (in_wait) begin
      if (got_resp) begin
        rsp_valid_d   = 1'b1;
        rsp_code_d    = out_resp;
        rsp_data_d    = out_data;
        rsp_timeout_d = 1'b0;
      end else if (expired) begin
        rsp_valid_d   = 1'b1;
        rsp_code_d    = RSP_NONE;
        rsp_data_d    = '0;
        rsp_timeout_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      cmd_q         <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      unexp_q       <= 1'b0;
    end else begin
      cmd_q         <= cmd_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_code_q    <= rsp_code_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      unexp_q       <= unexp_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign unexp_rsp   = unexp_q;

endmodule

`default_nettype wire

// File: tb/tb_calc1_req_driver.sv
// ============================================================================
// Module  : tb_calc1_req_driver
// Brief   : Self-checking bench for calc1_req_driver with a transaction-level
//           reference model of the per-cycle port behaviour.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_calc1_req_driver;

  localparam int T = 8;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cmd = '0;
  logic [31:0] req_op1 = '0;
  logic [31:0] req_op2 = '0;
  logic [3:0]  reqcmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp = '0;
  logic [31:0] out_data = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        unexp_rsp;

  calc1_req_driver #(.TIMEOUT_CYCLES(T)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .reqcmd_out  (reqcmd_out),
    .req_data_out(req_data_out),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .rsp_valid   (rsp_valid),
    .rsp_code    (rsp_code),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .unexp_rsp   (unexp_rsp)
  );

  always #5 c_clk = ~c_clk;

  int total = 0;
  int bad   = 0;

  // Last reported completion, as the model sees it
  logic [1:0]  h_code  = '0;
  logic [31:0] h_data  = '0;
  logic        h_to    = 1'b0;
  logic        h_unexp = 1'b0;

  logic [73:0] obs  [0:31];
  logic [73:0] expv [0:31];

  // {ready, cmd, data, valid, code, rdata, timeout, unexp}
  function automatic logic [73:0] pack_out();
    return {req_ready, reqcmd_out, req_data_out, rsp_valid, rsp_code,
            rsp_data, rsp_timeout, unexp_rsp};
  endfunction

  // One request; response arrives in WAIT cycle d (0-based), d>=T means none.
  // Called one time unit after a rising edge; returns in the same phase.
  task automatic drive_txn(input logic [3:0] cmd, input logic [31:0] a, b,
                           input int d, input logic [1:0] resp,
                           input logic [31:0] rdata, output int len);
    len = (d < T) ? 5 + d : 4 + T;
    for (int c = 0; c < len; c++) begin
      req_valid = (c == 0);
      req_cmd   = (c == 0) ? cmd : 4'($urandom);
      req_op1   = (c == 0) ? a : $urandom;
      req_op2   = (c == 0) ? b : $urandom;
      out_resp  = (d < T && c == 3 + d) ? resp : 2'd0;
      out_data  = (d < T && c == 3 + d) ? rdata : $urandom;
      #1 obs[c] = pack_out();
      @(posedge c_clk);
      #1;
    end
    req_valid = 1'b0;
    out_resp  = 2'd0;
  endtask

  // Expected trace: accept, op1 beat, op2 beat, wait cycles, completion in IDLE
  task automatic model_txn(input logic [3:0] cmd, input logic [31:0] a, b,
                           input int d, input logic [1:0] resp,
                           input logic [31:0] rdata, input int len);
    for (int c = 0; c < len; c++) begin
      logic pulse;
      pulse = (c == len - 1);
      if (pulse) begin
        if (d < T) begin
          h_code = resp; h_data = rdata; h_to = 1'b0;
        end else begin
          h_code = 2'd0; h_data = 32'd0; h_to = 1'b1;
        end
      end
      expv[c] = {(c == 0) || pulse,
                 (c == 1) ? cmd : 4'd0,
                 (c == 1) ? a : ((c == 2) ? b : 32'd0),
                 pulse, h_code, h_data, h_to, h_unexp};
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (pack_out() !== 74'd0) begin
      bad++; $display("FAIL reset_held got=%h exp=%h", pack_out(), 74'd0);
    end
    @(posedge c_clk); #1;
    reset = 1'b0;
    #1;
    total++;
    if (pack_out() !== {1'b1, 73'd0}) begin
      bad++; $display("FAIL reset_released got=%h exp=%h", pack_out(), {1'b1, 73'd0});
    end
    @(posedge c_clk); #1;
  endtask

  task automatic test_add();
    int len;
    drive_txn(4'd1, 32'd5, 32'd7, 0, 2'd1, 32'd12, len);
    model_txn(4'd1, 32'd5, 32'd7, 0, 2'd1, 32'd12, len);
    for (int c = 0; c < len; c++) begin
      total++;
      if (obs[c] !== expv[c]) begin
        bad++; $display("FAIL add c=%0d got=%h exp=%h", c, obs[c], expv[c]);
      end
    end
  endtask

  task automatic test_invalid_cmd();
    int len;
    drive_txn(4'd3, 32'h1234, 32'h5678, 2, 2'd2, 32'hdead_beef, len);
    model_txn(4'd3, 32'h1234, 32'h5678, 2, 2'd2, 32'hdead_beef, len);
    for (int c = 0; c < len; c++) begin
      total++;
      if (obs[c] !== expv[c]) begin
        bad++; $display("FAIL invalid_cmd c=%0d got=%h exp=%h", c, obs[c], expv[c]);
      end
    end
  endtask

  task automatic test_timeout();
    int len;
    drive_txn(4'd2, 32'd100, 32'd1, T, 2'd0, 32'd0, len);
    model_txn(4'd2, 32'd100, 32'd1, T, 2'd0, 32'd0, len);
    for (int c = 0; c < len; c++) begin
      total++;
      if (obs[c] !== expv[c]) begin
        bad++; $display("FAIL timeout c=%0d got=%h exp=%h", c, obs[c], expv[c]);
      end
    end
  endtask

  task automatic test_last_cycle_resp();
    int len;
    drive_txn(4'd5, 32'd1, 32'd4, T - 1, 2'd1, 32'd16, len);
    model_txn(4'd5, 32'd1, 32'd4, T - 1, 2'd1, 32'd16, len);
    for (int c = 0; c < len; c++) begin
      total++;
      if (obs[c] !== expv[c]) begin
        bad++; $display("FAIL last_cycle_resp c=%0d got=%h exp=%h", c, obs[c], expv[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      int len;
      int d;
      logic [3:0]  cmd;
      logic [31:0] a, b, rd;
      logic [1:0]  rs;
      cmd = 4'($urandom);
      a   = $urandom;
      b   = $urandom;
      rd  = $urandom;
      rs  = 2'($urandom_range(1, 3));
      d   = $urandom_range(0, T);
      drive_txn(cmd, a, b, d, rs, rd, len);
      model_txn(cmd, a, b, d, rs, rd, len);
      for (int c = 0; c < len; c++) begin
        total++;
        if (obs[c] !== expv[c]) begin
          bad++; $display("FAIL random n=%0d d=%0d c=%0d got=%h exp=%h", n, d, c, obs[c], expv[c]);
        end
      end
    end
  endtask

  // Request held high: the second one may only be taken once IDLE is reached
  task automatic test_back_to_back();
    logic [3:0]  ac, bc;
    logic [31:0] aa, ab, ba, bb, rda, rdb;
    ac = 4'd1; aa = $urandom; ab = $urandom; rda = $urandom;
    bc = 4'd6; ba = $urandom; bb = $urandom; rdb = $urandom;
    for (int c = 0; c < 9; c++) begin
      logic [37:0] got, exp;
      req_valid = (c <= 4);
      req_cmd   = (c == 0) ? ac : bc;
      req_op1   = (c == 0) ? aa : ba;
      req_op2   = (c == 0) ? ab : bb;
      out_resp  = (c == 3 || c == 7) ? 2'd1 : 2'd0;
      out_data  = (c == 3) ? rda : rdb;
      exp = {(c == 0 || c == 4 || c == 8),
             (c == 1) ? ac : ((c == 5) ? bc : 4'd0),
             (c == 1) ? aa : (c == 2) ? ab : (c == 5) ? ba : (c == 6) ? bb : 32'd0,
             (c == 4 || c == 8)};
      #1 got = {req_ready, reqcmd_out, req_data_out, rsp_valid};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL back_to_back c=%0d got=%h exp=%h", c, got, exp);
      end
      if (c == 8) begin
        total++;
        if (rsp_data !== rdb || rsp_code !== 2'd1) begin
          bad++; $display("FAIL back_to_back_rsp got=%h/%0d exp=%h/1", rsp_data, rsp_code, rdb);
        end
      end
      @(posedge c_clk); #1;
    end
    req_valid = 1'b0;
    out_resp  = 2'd0;
    h_code = 2'd1; h_data = rdb; h_to = 1'b0;
  endtask

  // Reset during WAIT aborts silently; a late response then flags unexp_rsp
  task automatic test_reset_mid();
    int len;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 0);
      req_cmd = 4'd2; req_op1 = 32'd9; req_op2 = 32'd3;
      @(posedge c_clk); #1;
    end
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (pack_out() !== 74'd0) begin
      bad++; $display("FAIL reset_mid_async got=%h exp=%h", pack_out(), 74'd0);
    end
    @(posedge c_clk); #1;
    out_resp = 2'd1; out_data = 32'd6;
    @(posedge c_clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_no_pulse got=%b exp=0", rsp_valid);
    end
    reset = 1'b0;
    out_resp = 2'd0;
    #1;
    total++;
    if (pack_out() !== {1'b1, 73'd0}) begin
      bad++; $display("FAIL reset_mid_idle got=%h exp=%h", pack_out(), {1'b1, 73'd0});
    end
    @(posedge c_clk); #1;
    out_resp = 2'd2;
    @(posedge c_clk); #1;
    out_resp = 2'd0;
    #1;
    total++;
    if (pack_out() !== {1'b1, 72'd0, 1'b1}) begin
      bad++; $display("FAIL unexp_rsp got=%h exp=%h", pack_out(), {1'b1, 72'd0, 1'b1});
    end
    @(posedge c_clk); #1;
    h_code = '0; h_data = '0; h_to = 1'b0; h_unexp = 1'b1;
    drive_txn(4'd1, 32'd20, 32'd22, 1, 2'd1, 32'd42, len);
    model_txn(4'd1, 32'd20, 32'd22, 1, 2'd1, 32'd42, len);
    for (int c = 0; c < len; c++) begin
      total++;
      if (obs[c] !== expv[c]) begin
        bad++; $display("FAIL unexp_sticky c=%0d got=%h exp=%h", c, obs[c], expv[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_invalid_cmd();
    test_timeout();
    test_last_cycle_resp();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
